inert_sensor_serf: RTL and testbench
====================================

INERT_SENSOR_SERF -- requirements
Module: inert_sensor_serf

Interface
REQ-001 The block SHALL have parameter INT_PERIOD, default 4096, giving the clk cycles between measurement-ready events.
REQ-002 The block SHALL have input clk, 1 bit: system clock, all state on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have input SS_n, 1 bit: SPI select, active low.
REQ-005 The block SHALL have input SCLK, 1 bit: SPI clock, mode 0 (idle low).
REQ-006 The block SHALL have input MOSI, 1 bit: command/data from the monarch, MSB first.
REQ-007 The block SHALL have output MISO, 1 bit: read data to the monarch.
REQ-008 The block SHALL have output INT, 1 bit: measurement ready, level, active high.
REQ-009 The block SHALL have inputs ptch_rt, roll_rt, yaw_rt, ax, ay, each 16-bit signed: live sensor values.
REQ-010 The block SHALL have output setup_done, 1 bit: all three configuration registers hold their required values.

Function
REQ-011 SS_n, SCLK and MOSI SHALL pass through a 2-flop synchronizer; SCLK rise and fall are detected from the synchronized copies, 3 clk latency, with SCLK phases >= 4 clk.
REQ-012 The transaction FSM SHALL have two states: IDLE and SHIFT; synchronized SS_n fall moves IDLE->SHIFT, clears the 5-bit bit counter and the 16-bit shift register.
REQ-013 In SHIFT, each SCLK rise SHALL shift MOSI into shift_reg[0] and increment the bit counter; MISO SHALL equal shift_reg[15] at all times.
REQ-014 On the 8th rise, the command byte SHALL be captured (bit7 = 1 read, bits6:0 = address) and shift_reg[15:8] loaded with the read byte in the same cycle.
REQ-015 Read map: 0x0D/0x11/0x14 SHALL return config register contents; 0x22/0x23 ptch L/H; 0x24/0x25 roll; 0x26/0x27 yaw; 0x28/0x29 ax; 0x2A/0x2B ay, all from the snapshot registers; any other address SHALL return 0x00.
REQ-016 Synchronized SS_n rise with bit count = 16 and a write command SHALL load the received low byte into config register 0x0D, 0x11 or 0x14; writes to other addresses are ignored.
REQ-017 SS_n rise with bit count != 16 SHALL abort: no register write, no INT clear, return to IDLE.
REQ-018 The INT timer SHALL count only while reg 0x0D bit1 = 1, wrap at INT_PERIOD-1, and otherwise hold at 0.
REQ-019 At timer terminal count with INT low, the block SHALL copy all five inputs into the snapshot registers and set INT the next cycle.
REQ-020 At terminal count with INT already high, the snapshot SHALL NOT update and the timer SHALL restart.
REQ-021 INT SHALL clear on SS_n rise that completes a 16-bit read of address 0x27.
REQ-022 If terminal count and the 0x27 read completion occur in the same cycle, the clear SHALL win; the snapshot SHALL NOT update.
REQ-023 setup_done SHALL be 1 iff reg 0x0D = 0x02, reg 0x11 = 0x60 and reg 0x14 = 0x40.

Reset
REQ-024 Asserting rst_n low SHALL force, at any time including mid-transaction: FSM IDLE, shift register 0 (MISO 0), INT 0, timer 0, config and snapshot registers 0, setup_done 0, and synchronizer flops to idle (SS_n 1, SCLK 0).

Structure
REQ-025 Package inert_pkg SHALL hold the register address constants and the FSM state enum.
REQ-026 A sub-module spi_sync_edge SHALL implement the synchronizers and SCLK/SS_n edge detection; all other logic stays in this module.

Verification
REQ-027 The bench SHALL write 0x0D02, 0x1160, 0x1440 -> setup_done rises after the third SS_n rise, and INT stays 0 before the first write.
REQ-028 The bench SHALL run with INT_PERIOD = 64 and yaw_rt = 16'h1234 -> INT rises 65 clk after the 0x0D02 write, read 0xA600 returns 0x34, and read 0xA700 returns 0x12 and clears INT.
REQ-029 The bench SHALL change yaw_rt to 16'h5678 after INT rises and before the reads -> the reads still return 0x34 and 0x12.
REQ-030 The bench SHALL raise SS_n after 10 bits of 0x2755 -> reg 0x11 is unchanged and INT stays set.
REQ-031 The bench SHALL leave INT unserviced for 3 periods -> the snapshot holds its first value, and reads return that value.
REQ-032 The bench SHALL assert rst_n during bit 12 of a read -> MISO 0, INT 0, setup_done 0, and the next full transaction works normally.

Source files
------------

// File: rtl/inert_pkg.sv
// Shared definitions for the inertial-sensor SPI responder: register map,
// required setup values, snapshot layout and transaction states.
package inert_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [6:0] REG_CTRL   = 7'h0D;
  localparam logic [6:0] REG_CFG_G  = 7'h11;
  localparam logic [6:0] REG_CFG_XL = 7'h14;
  localparam logic [6:0] REG_PTCH_L = 7'h22;
  localparam logic [6:0] REG_PTCH_H = 7'h23;
  localparam logic [6:0] REG_ROLL_L = 7'h24;
  localparam logic [6:0] REG_ROLL_H = 7'h25;
  localparam logic [6:0] REG_YAW_L  = 7'h26;
  localparam logic [6:0] REG_YAW_H  = 7'h27;
  localparam logic [6:0] REG_AX_L   = 7'h28;
  localparam logic [6:0] REG_AX_H   = 7'h29;
  localparam logic [6:0] REG_AY_L   = 7'h2A;
  localparam logic [6:0] REG_AY_H   = 7'h2B;

  localparam logic [7:0] SETUP_CTRL   = 8'h02;
  localparam logic [7:0] SETUP_CFG_G  = 8'h60;
  localparam logic [7:0] SETUP_CFG_XL = 8'h40;

  typedef struct packed {
    logic [15:0] ptch;
    logic [15:0] roll;
    logic [15:0] yaw;
    logic [15:0] ax;
    logic [15:0] ay;
  } snap_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for the SPI pins plus a third stage on SS_n and SCLK
// for edge detection against the synchronized copies.
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ss_n,
  input  logic sclk,
  input  logic mosi,
  output logic ss_fall,
  output logic ss_rise,
  output logic sclk_rise,
  output logic mosi_s
);

  logic [2:0] ss_q;
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= '1;
      sclk_q <= '0;
      mosi_q <= '0;
    end else begin
      ss_q   <= {ss_q[1:0], ss_n};
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  // MOSI and SCLK see the same synchronizer depth, so the data bit is aligned with its rise.
  assign ss_fall   =  ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] &  ss_q[1];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign mosi_s    =  mosi_q[1];

endmodule

// File: rtl/inert_sensor_serf.sv
// SPI-mode-0 inertial sensor responder: three config registers, a periodic
// measurement snapshot of five live inputs, and a level INT cleared by reading 0x27.
module inert_sensor_serf
  import inert_pkg::*;
#(
  parameter int unsigned INT_PERIOD = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  output logic               MISO,
  output logic               INT,
  input  logic signed [15:0] ptch_rt,
  input  logic signed [15:0] roll_rt,
  input  logic signed [15:0] yaw_rt,
  input  logic signed [15:0] ax,
  input  logic signed [15:0] ay,
  output logic               setup_done
);

  localparam int unsigned TW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;

  logic ss_fall, ss_rise, sclk_rise, mosi_s;

  spi_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n      (SS_n),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .sclk_rise (sclk_rise),
    .mosi_s    (mosi_s)
  );

  state_t        state;
  logic [4:0]    bit_cnt;
  logic [15:0]   shift_reg;
  logic [7:0]    cmd;
  logic [7:0]    reg_ctrl, reg_cfg_g, reg_cfg_xl;
  logic [TW-1:0] timer;
  logic          tc_q;
  snap_t         snap;

  logic [6:0] rd_addr;
  logic [7:0] rd_byte;
  logic       xfer_done, wr_en, int_clr, tc;

  // Address is complete only with the MOSI bit arriving on the 8th rise.
  assign rd_addr = {shift_reg[5:0], mosi_s};

  always_comb begin
    rd_byte = '0;
    unique case (rd_addr)
      REG_CTRL:   rd_byte = reg_ctrl;
      REG_CFG_G:  rd_byte = reg_cfg_g;
      REG_CFG_XL: rd_byte = reg_cfg_xl;
      REG_PTCH_L: rd_byte = snap.ptch[7:0];
      REG_PTCH_H: rd_byte = snap.ptch[15:8];
      REG_ROLL_L: rd_byte = snap.roll[7:0];
      REG_ROLL_H: rd_byte = snap.roll[15:8];
      REG_YAW_L:  rd_byte = snap.yaw[7:0];
      REG_YAW_H:  rd_byte = snap.yaw[15:8];
      REG_AX_L:   rd_byte = snap.ax[7:0];
      REG_AX_H:   rd_byte = snap.ax[15:8];
      REG_AY_L:   rd_byte = snap.ay[7:0];
      REG_AY_H:   rd_byte = snap.ay[15:8];
      default:    rd_byte = '0;
    endcase
  end

  assign xfer_done = (state == SHIFT) && ss_rise && (bit_cnt == 5'd16);
  assign wr_en     = xfer_done && !cmd[7];
  assign int_clr   = xfer_done && cmd[7] && (cmd[6:0] == REG_YAW_H);
  assign tc        = reg_ctrl[1] && (timer == TW'(INT_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      cmd        <= '0;
      reg_ctrl   <= '0;
      reg_cfg_g  <= '0;
      reg_cfg_xl <= '0;
      timer      <= '0;
      tc_q       <= 1'b0;
      INT        <= 1'b0;
      snap       <= '0;
    end else begin
      if (!reg_ctrl[1])
        timer <= '0;
      else if (tc)
        timer <= '0;
      else
        timer <= timer + 1'b1;
      tc_q <= tc;

      // A completing 0x27 read beats a simultaneous terminal count.
      if (int_clr)
        INT <= 1'b0;
      else if (tc_q && !INT) begin
        INT  <= 1'b1;
        snap <= '{ptch: ptch_rt, roll: roll_rt, yaw: yaw_rt, ax: ax, ay: ay};
      end

      if (wr_en) begin
        unique case (cmd[6:0])
          REG_CTRL:   reg_ctrl   <= shift_reg[7:0];
          REG_CFG_G:  reg_cfg_g  <= shift_reg[7:0];
          REG_CFG_XL: reg_cfg_xl <= shift_reg[7:0];
          default:    ;
        endcase
      end

      unique case (state)
        IDLE: begin
          if (ss_fall) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            if (bit_cnt != '1)
              bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              cmd       <= {shift_reg[6:0], mosi_s};
              shift_reg <= {rd_byte, shift_reg[6:0], mosi_s};
            end else begin
              shift_reg <= {shift_reg[14:0], mosi_s};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MISO       = shift_reg[15];
  assign setup_done = (reg_ctrl == SETUP_CTRL) && (reg_cfg_g == SETUP_CFG_G) &&
                      (reg_cfg_xl == SETUP_CFG_XL);

endmodule

// File: tb/tb_inert_sensor_serf.sv
// Directed-plus-random bench for inert_sensor_serf with a register-map model.
module tb_inert_sensor_serf;

  logic clk = 1'b0;
  logic rst_n, SS_n, SCLK, MOSI;
  logic MISO, INT, setup_done;
  logic signed [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_ctrl, m_g, m_xl;
  logic [15:0] m_snap [5];

  always #5 clk = ~clk;

  inert_sensor_serf #(.INT_PERIOD(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SS_n       (SS_n),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .INT        (INT),
    .ptch_rt    (ptch_rt),
    .roll_rt    (roll_rt),
    .yaw_rt     (yaw_rt),
    .ax         (ax),
    .ay         (ay),
    .setup_done (setup_done)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [6:0] a);
    int idx;
    if (a == 7'h0D) return m_ctrl;
    if (a == 7'h11) return m_g;
    if (a == 7'h14) return m_xl;
    if (a >= 7'h22 && a <= 7'h2B) begin
      idx = (int'(a) - 'h22) / 2;
      return a[0] ? m_snap[idx][15:8] : m_snap[idx][7:0];
    end
    return 8'h00;
  endfunction

  function automatic logic exp_setup();
    return (m_ctrl == 8'h02) && (m_g == 8'h60) && (m_xl == 8'h40);
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    if (a == 7'h0D) m_ctrl = d;
    if (a == 7'h11) m_g = d;
    if (a == 7'h14) m_xl = d;
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_g = '0; m_xl = '0;
    for (int i = 0; i < 5; i++) m_snap[i] = '0;
  endtask

  task automatic rand_inputs();
    ptch_rt = 16'($urandom);
    roll_rt = 16'($urandom);
    yaw_rt  = 16'($urandom);
    ax      = 16'($urandom);
    ay      = 16'($urandom);
  endtask

  task automatic ss_low();
    repeat (4) @(negedge clk);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Mode 0: data set while SCLK low, MISO sampled just before each rise.
  task automatic shift_bits(input logic [15:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      MOSI = tx[15 - i];
      repeat (4) @(negedge clk);
      if (i >= 8) rx = {rx[6:0], MISO};
      SCLK = 1'b1;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic xfer(input logic [15:0] tx, input int n, output logic [7:0] rx);
    ss_low();
    shift_bits(tx, n, rx);
    SS_n = 1'b1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rx;
    xfer({1'b0, a, d}, 16, rx);
    model_write(a, d);
  endtask

  // Reading 0x27 clears INT; fresh inputs go in before the clear lands so the next snapshot uses them.
  task automatic rd(input logic [6:0] a, input string tag);
    logic [7:0] rx;
    xfer({1'b1, a, 8'h00}, 16, rx);
    chk(tag, {8'h00, rx}, {8'h00, exp_read(a)});
    if (a == 7'h27) begin
      rand_inputs();
      repeat (3) @(negedge clk);
      chk({tag, "_int_clr"}, {15'd0, INT}, 16'd0);
    end
  endtask

  task automatic wait_int(input string tag);
    for (int i = 0; i < 300 && INT !== 1'b1; i++) @(negedge clk);
    chk(tag, {15'd0, INT}, 16'd1);
    m_snap[0] = ptch_rt; m_snap[1] = roll_rt; m_snap[2] = yaw_rt;
    m_snap[3] = ax;      m_snap[4] = ay;
  endtask

  initial begin
    logic [7:0] rx;
    logic [6:0] a;
    logic [7:0] d;

    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    rand_inputs();
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_miso", {15'd0, MISO}, 16'd0);
    chk("rst_int", {15'd0, INT}, 16'd0);
    chk("rst_setup", {15'd0, setup_done}, 16'd0);
    rst_n = 1'b1;

    repeat (200) @(negedge clk);
    chk("int_before_write", {15'd0, INT}, 16'd0);

    // Write lands 3 clocks after SS_n rises; INT follows 65 clocks after that.
    yaw_rt = 16'h1234;
    wr(7'h0D, 8'h02);
    repeat (67) @(posedge clk);
    #1 chk("int_early", {15'd0, INT}, 16'd0);
    @(posedge clk);
    #1 chk("int_rise", {15'd0, INT}, 16'd1);
    m_snap[0] = ptch_rt; m_snap[1] = roll_rt; m_snap[2] = yaw_rt;
    m_snap[3] = ax;      m_snap[4] = ay;
    yaw_rt = 16'h5678;
    ptch_rt = 16'($urandom); ax = 16'($urandom);

    repeat (4) @(negedge clk);
    chk("setup_after_1", {15'd0, setup_done}, 16'd0);
    wr(7'h11, 8'h60);
    repeat (4) @(negedge clk);
    chk("setup_after_2", {15'd0, setup_done}, 16'd0);
    wr(7'h14, 8'h40);
    repeat (4) @(negedge clk);
    chk("setup_after_3", {15'd0, setup_done}, 16'd1);

    repeat (200) @(negedge clk);
    chk("int_unserviced", {15'd0, INT}, 16'd1);
    rd(7'h0D, "rd_ctrl");
    rd(7'h11, "rd_cfg_g");
    rd(7'h14, "rd_cfg_xl");
    for (int i = 'h22; i <= 'h2B; i++)
      if (i != 'h27) rd(7'(i), $sformatf("rd_snap_%0h", i));
    rd(7'h26, "rd_yaw_l");
    chk("yaw_l_const", {8'h00, exp_read(7'h26)}, 16'h0034);
    rd(7'h27, "rd_yaw_h");

    // Aborted transfers: neither a partial write nor a partial 0x27 read has effect.
    wait_int("int_wait_abort");
    xfer(16'h2755, 10, rx);
    repeat (4) @(negedge clk);
    chk("abort_wr_int", {15'd0, INT}, 16'd1);
    rd(7'h11, "abort_cfg_g");
    xfer(16'hA700, 10, rx);
    repeat (4) @(negedge clk);
    chk("abort_rd_int", {15'd0, INT}, 16'd1);
    rd(7'h27, "abort_yaw_h");

    for (int r = 0; r < 4; r++) begin
      wait_int($sformatf("int_wait_r%0d", r));
      rand_inputs();
      a = 7'($urandom_range(0, 127));
      d = 8'($urandom);
      if (a == 7'h0D) d[1] = 1'b1;
      wr(a, d);
      repeat (4) @(negedge clk);
      chk($sformatf("setup_r%0d", r), {15'd0, setup_done}, {15'd0, exp_setup()});
      for (int k = 0; k < 5; k++) begin
        a = 7'($urandom_range(0, 63));
        if (a == 7'h27) a = 7'h26;
        rd(a, $sformatf("rd_r%0d_%0h", r, a));
      end
      rd(7'h27, $sformatf("rd_r%0d_yaw_h", r));
    end

    // Reset during bit 12 of a read.
    wr(7'h0D, 8'h02); wr(7'h11, 8'h60); wr(7'h14, 8'h40);
    wait_int("int_wait_rst");
    chk("setup_pre_rst", {15'd0, setup_done}, 16'd1);
    ss_low();
    shift_bits({1'b1, 7'h26, 8'h00}, 11, rx);
    MOSI = 1'b0;
    repeat (4) @(negedge clk);
    SCLK = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_miso", {15'd0, MISO}, 16'd0);
    chk("midrst_int", {15'd0, INT}, 16'd0);
    chk("midrst_setup", {15'd0, setup_done}, 16'd0);
    SCLK = 1'b0; SS_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rd(7'h0D, "post_rst_ctrl");
    wr(7'h0D, 8'h02);
    rd(7'h0D, "post_rst_ctrl_wr");
    wait_int("post_rst_int");
    rd(7'h26, "post_rst_yaw_l");
    rd(7'h27, "post_rst_yaw_h");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
